// File: rtl/iob_moving_sum_pkg.sv
// Shared types and helpers for the iob_moving_sum running-window accumulator.
package iob_moving_sum_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic int sum_width(input int data_w, input int n);
        return data_w + $clog2(n);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/iob_moving_sum_acc.sv
// Stage-2 datapath of iob_moving_sum: running sum, delayed-sample register,
// state-masked subtraction and saturating fill counter.
module iob_moving_sum_acc
    import iob_moving_sum_pkg::*;
#(
    parameter int DATA_W = 21,
    parameter int N      = 21,
    parameter int SUM_W  = DATA_W + $clog2(N),
    parameter int CNT_W  = $clog2(N + 1)
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_n_i,
    input  logic              rst_i,
    input  logic              upd_i,
    input  logic              full_i,
    input  logic [DATA_W-1:0] new_i,
    input  logic [DATA_W-1:0] dly_i,
    output logic [SUM_W-1:0]  sum_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              upd_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N);

    logic [DATA_W-1:0] old_q, old_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              upd_q, upd_d;
    logic [SUM_W-1:0]  sub_s;

    // Next-state for the accumulator; the subtrahend is masked until the
    // window is full so stale shift-register contents never leak in.
    always_comb begin
        sub_s = full_i ? SUM_W'(old_q) : '0;
        sum_d = sum_q;
        old_d = old_q;
        cnt_d = cnt_q;
        upd_d = 1'b0;
        if (rst_i) begin
            sum_d = '0;
            old_d = '0;
            cnt_d = '0;
            upd_d = 1'b0;
        end else if (upd_i) begin
            sum_d = sum_q + SUM_W'(new_i) - sub_s;
            old_d = dly_i;
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            upd_d = 1'b1;
        end else begin
            upd_d = 1'b0;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sum_q <= '0;
            old_q <= '0;
            cnt_q <= '0;
            upd_q <= 1'b0;
        end else if (cke_i) begin
            sum_q <= sum_d;
            old_q <= old_d;
            cnt_q <= cnt_d;
            upd_q <= upd_d;
        end
    end

    assign sum_o = sum_q;
    assign cnt_o = cnt_q;
    assign upd_o = upd_q;

endmodule

// File: rtl/iob_moving_sum.sv
// Running-window sum of the last N samples, paired with an external iob_shift_reg.
// Optional average output enabled by defining IOB_MOVING_SUM_AVG_EN (needs N = 2^k).
module iob_moving_sum
    import iob_moving_sum_pkg::*;
#(
    parameter int DATA_W = 21,
    parameter int N      = 21,
    parameter int SUM_W  = sum_width(DATA_W, N)
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_n_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] dly_data_i,
    output logic              shreg_en_o,
    output logic              shreg_rst_o,
    output logic [DATA_W-1:0] shreg_data_o,
    output logic [SUM_W-1:0]  sum_o,
    output logic              valid_o,
    output logic              upd_o
`ifdef IOB_MOVING_SUM_AVG_EN
    ,
    output logic [DATA_W-1:0] avg_o
`endif
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic              accept_s;
    logic              p1_q, p1_d;
    logic [DATA_W-1:0] d1_q, d1_d;
    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic              full_s;
    logic [CNT_W-1:0]  cnt_s;
    logic [SUM_W-1:0]  sum_s;

    // A reset in the same cycle as a strobe wins: the sample is never accepted.
    assign accept_s     = en_i & ~rst_i;
    assign shreg_en_o   = accept_s;
    assign shreg_rst_o  = rst_i;
    assign shreg_data_o = data_i;
    assign full_s       = (state_q == FULL);

    // Stage-1 capture of the accepted sample.
    always_comb begin
        p1_d = accept_s;
        if (accept_s) begin
            d1_d = data_i;
        end else begin
            d1_d = d1_q;
        end
    end

    // Stage-1 registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            p1_q <= 1'b0;
            d1_q <= '0;
        end else if (cke_i) begin
            p1_q <= p1_d;
            d1_q <= d1_d;
        end
    end

    iob_moving_sum_acc #(
        .DATA_W(DATA_W),
        .N     (N),
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_acc (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .arst_n_i(arst_n_i),
        .rst_i   (rst_i),
        .upd_i   (p1_q),
        .full_i  (full_s),
        .new_i   (d1_q),
        .dly_i   (dly_data_i),
        .sum_o   (sum_s),
        .cnt_o   (cnt_s),
        .upd_o   (upd_o)
    );

    // Window-state register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic; transitions only on a stage-2 update.
    always_comb begin
        state_d = state_q;
        if (rst_i) begin
            state_d = EMPTY;
        end else if (p1_q) begin
            case (state_q)
                EMPTY:   state_d = FILL;
                FILL:    state_d = (cnt_s == CNT_LAST) ? FULL : FILL;
                FULL:    state_d = FULL;
                default: state_d = EMPTY;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output decode; valid is registered alongside the state.
    always_comb begin
        valid_d = (state_d == FULL);
        valid_o = valid_q;
        sum_o   = sum_s;
    end

`ifdef IOB_MOVING_SUM_AVG_EN
    if (!is_pow2(N)) begin : g_n_check
        $error("iob_moving_sum: N must be a power of two when the average output is enabled");
    end

    assign avg_o = DATA_W'(sum_s >> $clog2(N));
`endif

endmodule
